// File: rtl/mem_responder.sv
// Word-addressed RAM slave for the unified CPU memory port: zero-wait instruction
// region, programmable wait states in the data region, debug preload port and statistics.
module mem_responder #(
  parameter int unsigned          ADDR_W      = 32,
  parameter int unsigned          XLEN        = 32,
  parameter int unsigned          DEPTH_WORDS = 512,
  parameter logic [ADDR_W-1:0]    DATA_BASE   = ADDR_W'(32'h0000_0200),
  parameter int unsigned          DATA_WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN-1:0]   mem_rdata,
  output logic              mem_ready,
  input  logic              stall_en,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [XLEN-1:0]   dbg_wdata,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       xfer_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t             state_q, state_nx;
  logic [CNT_W-1:0]   cnt_q, cnt_nx;
  logic [XLEN-1:0]    ram [DEPTH_WORDS];
  logic [IDX_W-1:0]   mem_idx;
  logic [IDX_W-1:0]   dbg_idx;
  logic               is_data;
  logic               waited;
  logic               cpu_wr;
  logic               unused_addr_bits;

  assign mem_idx = mem_addr[IDX_W+1:2];
  assign dbg_idx = dbg_addr[IDX_W+1:2];
  assign unused_addr_bits = ^dbg_addr;

  assign is_data   = (mem_addr >= DATA_BASE);
  assign waited    = mem_req && is_data && stall_en && (DATA_WAIT != 0);
  assign mem_rdata = ram[mem_idx];

  // A transfer caught by reset is abandoned, so the store is gated by rst_n too.
  assign cpu_wr = mem_req && mem_we && mem_ready && rst_n;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
    end
  end

  // Next-state and ready logic
  always_comb begin
    state_nx  = state_q;
    cnt_nx    = cnt_q;
    mem_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        mem_ready = mem_req && !waited;
        if (waited) begin
          state_nx = ST_WAIT;
          cnt_nx   = CNT_W'(DATA_WAIT - 1);
        end
      end
      ST_WAIT: begin
        mem_ready = (cnt_q == '0);
        if (!mem_req) begin
          state_nx = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_nx = cnt_q - CNT_W'(1);
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Statistics, wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      xfer_count   <= '0;
    end else begin
      if (mem_req && !mem_ready) stall_cycles <= stall_cycles + 32'd1;
      if (mem_req && mem_ready)  xfer_count   <= xfer_count + 32'd1;
    end
  end

  // RAM write ports; the debug write is last so it wins an index collision
  always_ff @(posedge clk) begin
    if (cpu_wr) ram[mem_idx] <= mem_wdata;
    if (dbg_we) ram[dbg_idx] <= dbg_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboarded bench for mem_responder: default build plus a DATA_WAIT=0 build on shared stimulus.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_we, stall_en, dbg_we;
  logic [31:0] mem_addr, mem_wdata, dbg_addr, dbg_wdata;
  logic [31:0] mem_rdata, stall_cycles, xfer_count;
  logic        mem_ready;
  logic [31:0] z_rdata, z_stall, z_xfer;
  logic        z_ready;

  int total = 0;
  int bad   = 0;
  int exp_stall = 0;
  int exp_xfer  = 0;
  logic [31:0] mdl [512];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  mem_responder dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .stall_en(stall_en), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .stall_cycles(stall_cycles), .xfer_count(xfer_count)
  );

  mem_responder #(.DATA_WAIT(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(z_rdata),
    .mem_ready(z_ready), .stall_en(1'b1), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .stall_cycles(z_stall), .xfer_count(z_xfer)
  );

  function automatic int idx(input logic [31:0] a);
    return int'(a[10:2]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_write(input logic [31:0] a, input logic [31:0] d);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    step();
    dbg_we = 1'b0;
    mdl[idx(a)] = d;
  endtask

  // Holds the request until ready (bounded); leaves mem_req asserted on return.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        output int waits, output logic [31:0] rd);
    bit done;
    mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = wd;
    waits = 0; done = 0; rd = 'x;
    while (!done && waits < 20) begin
      @(negedge clk);
      if (mem_ready) begin
        rd = mem_rdata;
        done = 1;
      end else begin
        waits++;
      end
      step();
    end
    if (done && we) mdl[idx(a)] = wd;
  endtask

  task automatic idle();
    mem_req = 1'b0; mem_we = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    stall_en = 1'b1; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL reset_stall got=%h exp=0", stall_cycles); end
    total++; if (xfer_count !== 32'd0) begin bad++; $display("FAIL reset_xfer got=%h exp=0", xfer_count); end
    total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", mem_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_preload();
    dbg_write(32'h0000_0000, 32'h2000_0093);
    dbg_write(32'h0000_0004, 32'h0070_0113);
    dbg_write(32'h0000_0200, 32'h1111_1111);
    dbg_write(32'h0000_0204, 32'h2222_2222);
    dbg_write(32'h0000_0208, 32'hA5A5_A5A5);
    dbg_write(32'h0000_020C, 32'h3333_3333);
  endtask

  task automatic test_ifetch();
    int w; logic [31:0] rd, e;
    stall_en = 1'b1;
    exp_q.push_back(mdl[idx(32'h0)]);
    access(1'b0, 32'h0000_0000, '0, w, rd);
    e = exp_q.pop_front();
    exp_xfer += 1;
    total++; if (w != 0) begin bad++; $display("FAIL ifetch_wait got=%0d exp=0", w); end
    total++; if (rd !== e) begin bad++; $display("FAIL ifetch_rdata got=%h exp=%h", rd, e); end
    total++; if (stall_cycles !== 32'(exp_stall)) begin bad++; $display("FAIL ifetch_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
    idle();
  endtask

  task automatic test_store_wait();
    int w; logic [31:0] rd;
    stall_en = 1'b1;
    access(1'b1, 32'h0000_0200, 32'h7, w, rd);
    exp_stall += 2; exp_xfer += 1;
    total++; if (w != 2) begin bad++; $display("FAIL store_wait got=%0d exp=2", w); end
    total++; if (stall_cycles !== 32'(exp_stall)) begin bad++; $display("FAIL store_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
    total++; if (xfer_count !== 32'(exp_xfer)) begin bad++; $display("FAIL store_xfer got=%0d exp=%0d", xfer_count, exp_xfer); end
  endtask

  task automatic test_back_to_back();
    int w; logic [31:0] rd, e;
    exp_q.push_back(mdl[idx(32'h200)]);
    access(1'b0, 32'h0000_0200, '0, w, rd);
    e = exp_q.pop_front();
    exp_stall += 2; exp_xfer += 1;
    total++; if (w != 2) begin bad++; $display("FAIL b2b_wait got=%0d exp=2", w); end
    total++; if (rd !== e) begin bad++; $display("FAIL b2b_rdata got=%h exp=%h", rd, e); end
    idle();
  endtask

  task automatic test_nostall();
    int w; logic [31:0] rd, e;
    stall_en = 1'b0;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0204; mem_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL nostall_ready got=%b exp=1", mem_ready); end
    total++; if (z_ready !== 1'b1) begin bad++; $display("FAIL zwait_ready got=%b exp=1", z_ready); end
    step();
    mdl[idx(32'h204)] = 32'hDEAD_BEEF;
    exp_xfer += 1;
    idle();
    total++; if (stall_cycles !== 32'(exp_stall)) begin bad++; $display("FAIL nostall_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
    exp_q.push_back(mdl[idx(32'h204)]);
    access(1'b0, 32'h0000_0204, '0, w, rd);
    e = exp_q.pop_front();
    exp_xfer += 1;
    total++; if (w != 0 || rd !== e) begin bad++; $display("FAIL nostall_readback got=%h/%0d exp=%h/0", rd, w, e); end
    total++; if (z_stall !== 32'd0) begin bad++; $display("FAIL zwait_stall got=%0d exp=0", z_stall); end
    idle();
  endtask

  task automatic test_abort();
    int w; logic [31:0] rd, e;
    stall_en = 1'b1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0208; mem_wdata = 32'h0000_0BAD;
    @(negedge clk);
    total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b exp=0", mem_ready); end
    step();
    exp_stall += 1;
    idle();
    exp_q.push_back(mdl[idx(32'h208)]);
    access(1'b0, 32'h0000_0208, '0, w, rd);
    e = exp_q.pop_front();
    exp_stall += 2; exp_xfer += 1;
    total++; if (w != 2) begin bad++; $display("FAIL abort_fresh_wait got=%0d exp=2", w); end
    total++; if (rd !== e) begin bad++; $display("FAIL abort_unchanged got=%h exp=%h", rd, e); end
    idle();
    total++; if (stall_cycles !== 32'(exp_stall)) begin bad++; $display("FAIL abort_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
    total++; if (xfer_count !== 32'(exp_xfer)) begin bad++; $display("FAIL abort_xfer got=%0d exp=%0d", xfer_count, exp_xfer); end
  endtask

  task automatic test_collision();
    int w; logic [31:0] rd, e;
    logic [31:0] la [3];
    stall_en = 1'b0;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0200; mem_wdata = 32'h0000_CAFE;
    dbg_we = 1'b1; dbg_addr = 32'h0000_0200; dbg_wdata = 32'hD0D0_D0D0;
    step();
    mdl[idx(32'h200)] = 32'hD0D0_D0D0;
    exp_xfer += 1;
    mem_addr = 32'h0000_0204; mem_wdata = 32'h4444_4444;
    dbg_addr = 32'h0000_020C; dbg_wdata = 32'h5555_5555;
    step();
    mdl[idx(32'h204)] = 32'h4444_4444;
    mdl[idx(32'h20C)] = 32'h5555_5555;
    exp_xfer += 1;
    dbg_we = 1'b0;
    idle();
    la[0] = 32'h200; la[1] = 32'h204; la[2] = 32'h20C;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mdl[idx(la[i])]);
      access(1'b0, la[i], '0, w, rd);
      e = exp_q.pop_front();
      exp_xfer += 1;
      total++; if (rd !== e) begin bad++; $display("FAIL collide_rd%0d got=%h exp=%h", i, rd, e); end
    end
    idle();
  endtask

  task automatic test_reset_mid_wait();
    int w; logic [31:0] rd, e;
    stall_en = 1'b1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0200; mem_wdata = 32'h0000_0055;
    step();
    step();
    @(negedge clk);
    total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL rstwait_ready got=%b exp=1", mem_ready); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    exp_stall = 0; exp_xfer = 0;
    @(negedge clk);
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL rstwait_stall got=%0d exp=0", stall_cycles); end
    total++; if (xfer_count !== 32'd0) begin bad++; $display("FAIL rstwait_xfer got=%0d exp=0", xfer_count); end
    step();
    stall_en = 1'b0;
    exp_q.push_back(mdl[idx(32'h200)]);
    access(1'b0, 32'h0000_0200, '0, w, rd);
    e = exp_q.pop_front();
    exp_xfer += 1;
    total++; if (rd !== e) begin bad++; $display("FAIL rstwait_nowrite got=%h exp=%h", rd, e); end
    idle();
    total++; if (xfer_count !== 32'(exp_xfer)) begin bad++; $display("FAIL final_xfer got=%0d exp=%0d", xfer_count, exp_xfer); end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_ifetch();
    test_store_wait();
    test_back_to_back();
    test_nostall();
    test_abort();
    test_collision();
    test_reset_mid_wait();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the cpu_top unified memory port (cpu_mem_req/we/addr/wdata/rdata/ready).
- Word-addressed RAM with zero-wait accesses below DATA_BASE (instruction region) and a programmable wait-state FSM at or above DATA_BASE (data region).
- Provides a preload/debug write port and stall/transfer statistics.
- Replaces behavioural memory models in benches and serves as the on-chip RAM slave in FPGA builds.

Parameters:
ADDR_W, 32, address width
XLEN, 32, data width
DEPTH_WORDS, 512, RAM depth in words (power of two)
DATA_BASE, 32'h0000_0200, first byte address of the wait-stated data region
DATA_WAIT, 2, ready-low cycles inserted per data-region access (0..15)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
mem_req  in  1  request valid; held with we/addr/wdata until ready
mem_we  in  1  1 = store, 0 = load
mem_addr  in  ADDR_W  byte address; bits [1:0] ignored
mem_wdata  in  XLEN  store data
mem_rdata  out  XLEN  load data, valid while mem_req && mem_ready
mem_ready  out  1  transfer completes on any cycle with mem_req && mem_ready
stall_en  in  1  1 = apply DATA_WAIT in data region; 0 = all accesses zero-wait
dbg_we  in  1  preload write strobe
dbg_addr  in  ADDR_W  preload byte address
dbg_wdata  in  XLEN  preload data
stall_cycles  out  32  count of cycles with mem_req && !mem_ready
xfer_count  out  32  count of completed transfers (mem_req && mem_ready)

Behaviour:
- Index = addr[log2(DEPTH_WORDS)+1:2]. Out-of-range addresses alias by truncation. No error response.
- mem_rdata = ram[index of mem_addr], combinational asynchronous read. It is undefined-but-stable when mem_req is 0; the bench checks it only while mem_req && mem_ready.
- is_data = (mem_addr >= DATA_BASE). waited = mem_req && is_data && stall_en && (DATA_WAIT != 0).
- FSM states:
  - IDLE: mem_ready = mem_req && !waited. If waited, go to WAIT and set cnt = DATA_WAIT-1; mem_ready = 0 this cycle.
  - WAIT: mem_ready = (cnt == 0).
    - If !mem_req: abort, go to IDLE. No write occurs and the counters do not increment for that cycle.
    - If mem_req && cnt != 0: cnt decrements.
    - If mem_req && cnt == 0: transfer completes and the next state is IDLE.
- Latency: a data access first presented at cycle T completes at T+DATA_WAIT. Instruction, non-stalled and DATA_WAIT=0 accesses complete at T.
- Back-to-back: after completion the FSM returns to IDLE, and a req still asserted next cycle is a new transaction that pays the full wait again.
- If mem_addr or mem_we changes while in WAIT with mem_req high (protocol violation), the FSM does not restart. The completing cycle uses the values present on that cycle.
- stall_en sampled only in IDLE. Deassertion during WAIT does not shorten the current wait.
- Store commit: ram[index] <= mem_wdata at the posedge where mem_req && mem_we && mem_ready. Loads never modify the RAM.
- Debug port: ram[dbg index] <= dbg_wdata at the posedge when dbg_we. If it collides with a CPU store to the same index in the same cycle, dbg wins. Different indices both write.
- stall_cycles and xfer_count increment by 1 per qualifying cycle and wrap modulo 2^32.
- Reset (rst_n low at posedge):
  - state = IDLE, cnt = 0, stall_cycles = 0, xfer_count = 0. mem_ready then follows the IDLE equation.
  - RAM contents are not reset.
  - Reset mid-WAIT abandons the transfer without writing.

Test Plan:
- Preload via dbg: ram[0]=addi x1,x0,0x200 etc. Instruction fetch at 0x0 with req=1 -> ready=1 same cycle; rdata=0x20000093; stall_cycles stays 0.
- stall_en=1, DATA_WAIT=2, store 0x7 to 0x200 -> ready low 2 cycles, high on 3rd; ram[0x80]=7 written exactly once; stall_cycles=2, xfer_count=1.
- Load from 0x200 immediately after that store (req held) -> new 2-cycle wait, then rdata=7 with ready=1.
- stall_en=0, store 0xDEADBEEF to 0x204 -> ready=1 same cycle; zero stalls. DATA_WAIT=0 build gives the same result with stall_en=1.
- Abort: data store to 0x208 with req dropped after 1 wait cycle -> FSM back to IDLE; ram[0x82] unchanged; a fresh request then waits the full 2 cycles.
- Collision and reset: dbg_we and CPU store both to 0x200 in the same cycle -> ram holds dbg_wdata. rst_n low during WAIT -> no write; stall_cycles=0 and xfer_count=0 next cycle.
